// File: rtl/bcd_display_scanner.sv
// Time-multiplexed scanner feeding a BCD-to-7-segment decoder on a common-anode display.
// New values are committed only at frame boundaries, so a frame never mixes old and new digits.
module bcd_display_scanner #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16,
  parameter int IDX_W       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lzb_en,
  output logic [3:0]            bcd_out,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp_out,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  load_ack,
  output logic                  frame_done
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0]      div_reg, div_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [4*N_DIGITS-1:0] cur_digits_reg, cur_digits_next;
  logic [N_DIGITS-1:0]   cur_dp_reg, cur_dp_next;
  logic [4*N_DIGITS-1:0] pend_digits_reg, pend_digits_next;
  logic [N_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
  logic                  pend_valid_reg, pend_valid_next;

  logic [3:0]            bcd_out_reg, bcd_out_next;
  logic [N_DIGITS-1:0]   an_reg, an_next;
  logic                  dp_out_reg, dp_out_next;
  logic [IDX_W-1:0]      digit_idx_reg;
  logic                  load_ack_reg, load_ack_next;
  logic                  frame_done_reg, frame_done_next;

  logic                  div_wrap;
  logic                  boundary;
  logic [N_DIGITS-1:0]   digit_zero;
  logic [N_DIGITS-1:0]   tail_zero;
  logic [3:0]            cur_d;
  logic                  blank;

  // Scan timing
  always_comb begin
    div_wrap = (div_reg == DIV_LAST);
    boundary = div_wrap && (idx_reg == IDX_LAST);
    div_next = div_wrap ? '0 : div_reg + 1'b1;
    idx_next = idx_reg;
    if (div_wrap) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
    frame_done_next = boundary;
  end

  // Load/commit handshake; a load on the boundary cycle bypasses the pending stage
  always_comb begin
    cur_digits_next  = cur_digits_reg;
    cur_dp_next      = cur_dp_reg;
    pend_digits_next = pend_digits_reg;
    pend_dp_next     = pend_dp_reg;
    pend_valid_next  = pend_valid_reg;
    load_ack_next    = 1'b0;
    if (boundary) begin
      if (load) begin
        cur_digits_next = digits_in;
        cur_dp_next     = dp_in;
        load_ack_next   = 1'b1;
      end else if (pend_valid_reg) begin
        cur_digits_next = pend_digits_reg;
        cur_dp_next     = pend_dp_reg;
        load_ack_next   = 1'b1;
      end
      pend_valid_next = 1'b0;
    end else if (load) begin
      pend_digits_next = digits_in;
      pend_dp_next     = dp_in;
      pend_valid_next  = 1'b1;
    end
  end

  // A digit counts as a leading zero only if it is 0 and has no decimal point
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_zero
      assign digit_zero[gi] = (cur_digits_next[4*gi +: 4] == 4'd0) && !cur_dp_next[gi];
    end
  endgenerate

  always_comb begin
    logic run;
    run = 1'b1;
    tail_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run = run & digit_zero[i];
      tail_zero[i] = run;
    end
  end

  // Outputs follow the next-state index and value so they move together with idx/cur
  always_comb begin
    cur_d        = cur_digits_next[4*idx_next +: 4];
    blank        = (cur_d > 4'd9) ||
                   (lzb_en && (idx_next != '0) && tail_zero[idx_next]);
    bcd_out_next = cur_d;
    an_next      = ~(AN_ONE << idx_next);
    dp_out_next  = cur_dp_next[idx_next];
    if (blank) begin
      an_next     = '1;
      dp_out_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg         <= '0;
      idx_reg         <= '0;
      cur_digits_reg  <= '0;
      cur_dp_reg      <= '0;
      pend_digits_reg <= '0;
      pend_dp_reg     <= '0;
      pend_valid_reg  <= 1'b0;
      bcd_out_reg     <= '0;
      an_reg          <= '1;
      dp_out_reg      <= 1'b0;
      digit_idx_reg   <= '0;
      load_ack_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      div_reg         <= div_next;
      idx_reg         <= idx_next;
      cur_digits_reg  <= cur_digits_next;
      cur_dp_reg      <= cur_dp_next;
      pend_digits_reg <= pend_digits_next;
      pend_dp_reg     <= pend_dp_next;
      pend_valid_reg  <= pend_valid_next;
      bcd_out_reg     <= bcd_out_next;
      an_reg          <= an_next;
      dp_out_reg      <= dp_out_next;
      digit_idx_reg   <= idx_next;
      load_ack_reg    <= load_ack_next;
      frame_done_reg  <= frame_done_next;
    end
  end

  assign bcd_out    = bcd_out_reg;
  assign an         = an_reg;
  assign dp_out     = dp_out_reg;
  assign digit_idx  = digit_idx_reg;
  assign load_ack   = load_ack_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with N_DIGITS=4, REFRESH_DIV=4 (16-cycle frames).
module tb_bcd_display_scanner;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lzb_en;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic        dp_out;
  logic [1:0]  digit_idx;
  logic        load_ack;
  logic        frame_done;

  int n_chk = 0;
  int n_bad = 0;
  int acks;

  bcd_display_scanner #(
    .N_DIGITS(4), .REFRESH_DIV(4), .DIV_W(16), .IDX_W(2)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .lzb_en(lzb_en), .bcd_out(bcd_out), .an(an), .dp_out(dp_out),
    .digit_idx(digit_idx), .load_ack(load_ack), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp);
    $display("load digits=%04h dp=%04b lzb=%0b", d, dp, lzb_en);
    load = 1'b1;
    digits_in = d;
    dp_in = dp;
    tick();
    load = 1'b0;
  endtask

  // Advance to the next frame_done cycle, counting load_ack pulses on the way
  task automatic wait_fd(output int n_ack);
    int n;
    n_ack = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (load_ack) n_ack++;
    end while (!frame_done && n < 40);
    chk("fd_seen", frame_done, 1);
  endtask

  // Starts on a frame_done cycle, checks each digit slot, ends on the next one
  task automatic show_frame(input logic [15:0] ean, input logic [15:0] ebcd, input logic [3:0] edp);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("d%0d_an", k), an, ean[4*k +: 4]);
      chk($sformatf("d%0d_bcd", k), bcd_out, ebcd[4*k +: 4]);
      chk($sformatf("d%0d_dp", k), dp_out, edp[k]);
      chk($sformatf("d%0d_idx", k), digit_idx, k);
      chk($sformatf("d%0d_fd", k), frame_done, 0);
      chk($sformatf("d%0d_ack", k), load_ack, 0);
      repeat (3) tick();
    end
    chk("fd_period", frame_done, 1);
    chk("ack_end", load_ack, 0);
    $display("frame an=%04h bcd=%04h dp=%04b checked", ean, ebcd, edp);
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    digits_in = '0;
    dp_in = '0;
    lzb_en = 1'b0;
    repeat (3) tick();
    chk("rst_an", an, 4'hf);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_dp", dp_out, 0);
    chk("rst_idx", digit_idx, 0);
    chk("rst_ack", load_ack, 0);
    chk("rst_fd", frame_done, 0);
    reset = 1'b0;

    // Basic scan of 1234
    pulse_load(16'h1234, 4'b0000);
    wait_fd(acks);
    chk("ack_1234", acks, 1);
    show_frame(16'h7BDE, 16'h1234, 4'b0000);

    // Leading-zero blanking
    lzb_en = 1'b1;
    pulse_load(16'h0007, 4'b0000);
    wait_fd(acks);
    chk("ack_0007", acks, 1);
    show_frame(16'hFFFE, 16'h0007, 4'b0000);

    pulse_load(16'h0000, 4'b0000);
    wait_fd(acks);
    chk("ack_0000", acks, 1);
    show_frame(16'hFFFE, 16'h0000, 4'b0000);

    // Decimal point keeps digit 2 lit
    pulse_load(16'h0050, 4'b0100);
    wait_fd(acks);
    chk("ack_0050", acks, 1);
    show_frame(16'hFBDE, 16'h0050, 4'b0100);

    // Two loads mid-frame: latest wins, old value stays until the boundary
    repeat (3) tick();
    pulse_load(16'h1111, 4'b0000);
    tick();
    pulse_load(16'h2222, 4'b0000);
    chk("old_bcd", bcd_out, 5);
    chk("old_an", an, 4'hd);
    wait_fd(acks);
    chk("ack_2222", acks, 1);
    show_frame(16'h7BDE, 16'h2222, 4'b0000);

    // Invalid BCD digit is dark
    pulse_load(16'h9A99, 4'b0000);
    wait_fd(acks);
    chk("ack_9a99", acks, 1);
    show_frame(16'h7FDE, 16'h9A99, 4'b0000);

    // Load on the boundary cycle commits immediately
    repeat (15) tick();
    $display("load digits=5678 dp=0000 on boundary");
    load = 1'b1;
    digits_in = 16'h5678;
    dp_in = 4'b0000;
    tick();
    load = 1'b0;
    chk("byp_ack", load_ack, 1);
    chk("byp_fd", frame_done, 1);
    chk("byp_bcd", bcd_out, 8);
    chk("byp_an", an, 4'he);
    show_frame(16'h7BDE, 16'h5678, 4'b0000);

    // Reset mid-frame discards a pending load
    repeat (2) tick();
    pulse_load(16'h4321, 4'b0000);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("mrst_an", an, 4'hf);
    chk("mrst_bcd", bcd_out, 0);
    chk("mrst_dp", dp_out, 0);
    chk("mrst_idx", digit_idx, 0);
    chk("mrst_ack", load_ack, 0);
    chk("mrst_fd", frame_done, 0);
    tick();
    reset = 1'b0;
    wait_fd(acks);
    chk("mrst_no_ack", acks, 0);
    show_frame(16'hFFFE, 16'h0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Upstream feeder for the BCD-to-7-segment decoder (`Decodificador`).
- Holds an N-digit BCD value and time-multiplexes one digit at a time onto the decoder's 4-bit `in` port.
- Drives the active-low anode enables and decimal point of a common-anode multi-digit display.
- Supports frame-synchronous tear-free updates through a load/ack handshake, leading-zero blanking, and blanking of invalid BCD codes.

Parameters:
- N_DIGITS, 4, number of display digits (2..8).
- REFRESH_DIV, 50000, clock cycles each digit stays lit (>=2).
- DIV_W, 16, width of the refresh divider counter (must hold REFRESH_DIV-1).
- IDX_W, 2, width of the digit index (clog2(N_DIGITS), minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  strobe, one cycle: capture digits_in/dp_in as the pending value.
- digits_in  in  4*N_DIGITS  BCD digits; [3:0] = digit 0 (least significant).
- dp_in  in  N_DIGITS  decimal-point request per digit, 1 = on.
- lzb_en  in  1  leading-zero blanking enable, sampled every cycle.
- bcd_out  out  4  BCD code of the current digit, to decoder `in`.
- an  out  N_DIGITS  anode enables, active-low, one-hot-low or all-high.
- dp_out  out  1  decimal point for the current digit, active-high.
- digit_idx  out  IDX_W  index of the digit currently shown.
- load_ack  out  1  one-cycle pulse when a pending value is committed.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:

Clock and reset:
- One clock domain. reset is synchronous and active-high, and has priority over all other inputs.
- Reset values:
  - div = 0, idx = 0.
  - cur_digits = 0, cur_dp = 0.
  - pend_valid = 0.
  - an = all 1s (dark), bcd_out = 0, dp_out = 0, digit_idx = 0.
  - load_ack = 0, frame_done = 0.
- Reset asserted mid-frame or with a load pending discards the pending value, and no load_ack is issued.

Refresh divider and scan:
- div increments every cycle. When div == REFRESH_DIV-1, it wraps to 0 and idx advances.
- idx increments modulo N_DIGITS; after N_DIGITS-1 it wraps to 0.
- frame_done pulses on the cycle the wrap from N_DIGITS-1 to 0 occurs (the frame boundary).

Handshake:
- load = 1 captures digits_in and dp_in into the pend registers and sets pend_valid.
- A second load before commit overwrites pend; the latest value wins, with no error.
- At the frame boundary with pend_valid = 1: pend is copied into cur, pend_valid clears, and load_ack pulses.
- If load coincides with the frame boundary cycle, digits_in/dp_in go directly to cur (bypass), pend_valid clears, and load_ack pulses.
- cur never changes mid-frame, so there is no tearing.

Output function (registered):
- Outputs are computed from the next-state idx and cur and registered, so they change on the same edge as idx/cur.
- Latency from the load strobe to the display is up to one frame (N_DIGITS*REFRESH_DIV cycles).
- d = cur_digits[4*idx+:4]:
  - bcd_out = d.
  - dp_out = cur_dp[idx].
  - digit_idx = idx.
- Blank condition: d > 9 (invalid BCD), OR (lzb_en AND idx != 0 AND all digits from idx up to N_DIGITS-1 are 0 AND cur_dp for those digits is 0).
- If the blank condition holds: an = all 1s and dp_out = 0.
- Otherwise: an = ~(1 << idx).
- Digit 0 is never blanked by leading-zero blanking, so a value of 0 shows "0".

Test Plan:
Use N_DIGITS = 4, REFRESH_DIV = 4.
- Reset, then load 0x1234, dp = 0 -> load_ack 1 cycle at the first frame boundary; an cycles 1110, 1101, 1011, 0111 with bcd_out 4, 3, 2, 1, each for 4 cycles; frame_done every 16 cycles.
- lzb_en = 1, load 0x0007 -> digit 0 shows an = 1110, bcd_out = 7; digits 1..3 give an = 1111. Then load 0x0000 -> only digit 0 lit, showing 0.
- lzb_en = 1, load 0x0050 with dp_in = 0100 -> digit 2 is lit (dp keeps it) with dp_out = 1; digit 3 is blanked; digit 1 shows 5; digit 0 shows 0.
- Load 0x1111 mid-frame, then 0x2222 two cycles later -> exactly one load_ack at the next boundary; display shows 2s only, and the old value persists until the boundary.
- Load 0x9A99 -> digit 2 (A) is dark with an = 1111; the other digits show 9.
- Load asserted exactly on the frame-boundary cycle -> committed in the same cycle with load_ack. Reset asserted mid-frame with a load pending -> all outputs return to reset values, and no load_ack follows.
